// File: rtl/soft_fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// soft_fifo_arb_pkg
// Shared types and helpers for the SoftFIFO write-port arbiter.
//   arb_state_t : arbiter state (IDLE = no grant, BURST = grant held)
//   clog2_safe  : $clog2 that never returns 0, so 1-entry widths stay legal
// -----------------------------------------------------------------------------
package soft_fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   function automatic int clog2_safe(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage : soft_fifo_arb_pkg

// File: rtl/rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Purely combinational round-robin selector. The request vector is rotated so
// that index last_grant+1 lands at bit 0, the lowest set bit is found, and the
// offset is mapped back to an absolute producer index.
// Ports:
//   req        in  NUM_REQ  request bits, one per producer
//   last_grant in  IDX_W    most recently granted index
//   any_req    out 1        at least one request bit set
//   next_idx   out IDX_W    winning index (don't-care when any_req = 0)
// -----------------------------------------------------------------------------
module rr_priority_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic               any_req,
   output logic [IDX_W-1:0]   next_idx
);

   logic [NUM_REQ-1:0] rotated;
   int                 start;
   int                 offset;
   logic               found;

   // NOTE: every variable written here gets a value before any branch reads
   // or conditionally overwrites it, so no path leaves a stale value (latch).
   always_comb begin
      start   = (int'(last_grant) + 1) % NUM_REQ;
      rotated = NUM_REQ'({req, req} >> start);
      offset  = 0;
      found   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && rotated[i]) begin
            found  = 1'b1;
            offset = i;
         end
      end
      any_req  = |req;
      next_idx = IDX_W'((start + offset) % NUM_REQ);
   end

endmodule : rr_priority_picker

// File: rtl/soft_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// soft_fifo_wr_arbiter
// Round-robin arbiter sharing one SoftFIFO write port among NUM_REQ producers.
// A grant lasts until the producer's last beat or BURST_MAX beats, whichever
// comes first, and each burst is followed by one IDLE cycle. Writes are never
// issued while the FIFO reports full.
// Ports:
//   clock       in  1                single clock, rising edge
//   reset_n     in  1                async assert, active-low
//   req_valid   in  NUM_REQ          per-producer beat valid
//   req_data    in  NUM_REQ*WIDTH    producer i at [i*WIDTH +: WIDTH]
//   req_last    in  NUM_REQ          final beat of a producer's packet
//   req_ready   out NUM_REQ          one-hot/zero, granted producer only
//   fifo_wrreq  out 1                FIFO write strobe
//   fifo_data   out WIDTH            FIFO write data
//   fifo_full   in  1                FIFO full flag
//   grant_id    out clog2(NUM_REQ)   current or most recent grant
//   busy        out 1                high while a grant is held
// -----------------------------------------------------------------------------
module soft_fifo_wr_arbiter
   import soft_fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int WIDTH     = 512,
   parameter int BURST_MAX = 8
) (
   input  logic                               clock,
   input  logic                               reset_n,
   input  logic [NUM_REQ-1:0]                 req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]           req_data,
   input  logic [NUM_REQ-1:0]                 req_last,
   output logic [NUM_REQ-1:0]                 req_ready,
   output logic                               fifo_wrreq,
   output logic [WIDTH-1:0]                   fifo_data,
   input  logic                               fifo_full,
   output logic [clog2_safe(NUM_REQ)-1:0]     grant_id,
   output logic                               busy
);

   localparam int               IDX_W    = clog2_safe(NUM_REQ);
   localparam int               CNT_W    = clog2_safe(BURST_MAX + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BURST_MAX);

   arb_state_t       state_q,      state_d;
   logic [IDX_W-1:0] grant_id_q,   grant_id_d;
   logic [IDX_W-1:0] last_grant_q, last_grant_d;
   logic [CNT_W-1:0] beat_cnt_q,   beat_cnt_d;
   logic [CNT_W-1:0] beat_cnt_inc;

   logic             any_req;
   logic [IDX_W-1:0] next_idx;
   logic             xfer;

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .any_req    (any_req),
      .next_idx   (next_idx)
   );

   // Data path is fully combinational: fifo_full gates ready and the write
   // strobe in the same cycle, which is what keeps wrreq && full impossible.
   always_comb begin
      req_ready = '0;
      xfer      = 1'b0;
      fifo_data = req_data[WIDTH-1:0];
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id_q == IDX_W'(i)) begin
            fifo_data = req_data[i*WIDTH +: WIDTH];
         end
      end
      if (state_q == BURST) begin
         req_ready[grant_id_q] = !fifo_full;
         xfer                  = req_valid[grant_id_q] && !fifo_full;
      end
      fifo_wrreq = xfer;
   end

   always_comb begin
      state_d      = state_q;
      grant_id_d   = grant_id_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      beat_cnt_inc = beat_cnt_q + CNT_W'(1);
      case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_id_d   = next_idx;
               last_grant_d = next_idx;
               beat_cnt_d   = '0;
               state_d      = BURST;
            end
         end
         BURST: begin
            // A stalled producer (valid low) keeps the grant; only a transfer
            // moves the counter or ends the burst.
            if (xfer) begin
               beat_cnt_d = beat_cnt_inc;
               if (req_last[grant_id_q] || (beat_cnt_inc == CNT_MAX)) begin
                  state_d = IDLE;
               end
            end
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of its neighbours regardless of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         grant_id_q   <= '0;
         last_grant_q <= LAST_IDX;   // producer 0 wins the first arbitration
         beat_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         grant_id_q   <= grant_id_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
      end
   end

   assign grant_id = grant_id_q;
   assign busy     = (state_q == BURST);

endmodule : soft_fifo_wr_arbiter
